// File: rtl/alu_issue_queue.sv
// Issue queue feeding a combinational ALU slice: buffers ops in a FIFO, issues
// the head entry to the slice and registers the returned result for downstream.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_A,
  input  logic [WIDTH-1:0]       in_B,
  input  logic [3:0]             in_opcode,
  output logic [WIDTH-1:0]       A,
  output logic [WIDTH-1:0]       B,
  output logic [3:0]             opcode,
  output logic                   en,
  input  logic [WIDTH-1:0]       result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [3:0]             out_opcode,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] EMPTY_C = {CW{1'b0}};

  logic [WIDTH-1:0] a_mem_r  [DEPTH];
  logic [WIDTH-1:0] b_mem_r  [DEPTH];
  logic [3:0]       op_mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_result_r;
  logic [3:0]       out_opcode_r;

  logic             in_ready_s;
  logic             push_s;
  logic             issue_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [3:0]       op_s;

  // Handshake decode and slice drive; the slice sees zeros whenever nothing issues.
  always_comb begin
    in_ready_s = (count_r != FULL_C);
    push_s     = in_valid & in_ready_s;
    issue_s    = (count_r != EMPTY_C) & (~out_valid_r | out_ready);
    if (issue_s) begin
      a_s  = a_mem_r[rd_ptr_r];
      b_s  = b_mem_r[rd_ptr_r];
      op_s = op_mem_r[rd_ptr_r];
    end else begin
      a_s  = {WIDTH{1'b0}};
      b_s  = {WIDTH{1'b0}};
      op_s = 4'b0000;
    end
  end

  // FIFO storage: written at wr_ptr on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_r[i]  <= {WIDTH{1'b0}};
        b_mem_r[i]  <= {WIDTH{1'b0}};
        op_mem_r[i] <= 4'b0000;
      end
    end else if (push_s) begin
      a_mem_r[wr_ptr_r]  <= in_A;
      b_mem_r[wr_ptr_r]  <= in_B;
      op_mem_r[wr_ptr_r] <= in_opcode;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= EMPTY_C;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, issue_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output register: captures the slice result on issue, otherwise drains or holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {WIDTH{1'b0}};
      out_opcode_r <= 4'b0000;
    end else if (issue_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= result;
      out_opcode_r <= op_s;
    end else if (out_valid_r & out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  assign in_ready   = in_ready_s;
  assign en         = issue_s;
  assign A          = a_s;
  assign B          = b_s;
  assign opcode     = op_s;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_opcode = out_opcode_r;
  assign count      = count_r;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with an XOR-only slice model and an
// in-order scoreboard of expected {result, opcode} pairs.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_op;
  logic [31:0] sl_a, sl_b;
  logic [3:0]  sl_op;
  logic        en;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_opcode;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int pops0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  // Slice model: only XOR is implemented, everything else returns zero.
  assign result = (sl_op == 4'b0100) ? (sl_a ^ sl_b) : 32'h0;

  alu_issue_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_a), .in_B(in_b), .in_opcode(in_op),
    .A(sl_a), .B(sl_b), .opcode(sl_op), .en(en), .result(result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    return (op == 4'b0100) ? (a ^ b) : 32'h0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    in_valid = v; in_a = a; in_b = b; in_op = op;
    #1;
  endtask

  // Record accepted pushes, check consumed results, then advance one clock.
  task automatic tick();
    logic [35:0] e;
    #1;
    if (in_valid && in_ready) exp_q.push_back({exp_res(in_a, in_b, in_op), in_op});
    if (out_valid && out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_out_result", {32'd0, out_result}, {32'd0, e[35:4]});
        chk("sb_out_opcode", {60'd0, out_opcode}, {60'd0, e[3:0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_en", en, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_slice_a", sl_a, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single XOR
    drive(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 4'b0100);
    chk("xor_no_bypass_en", en, 0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    chk("xor_en_issue", en, 1);
    chk("xor_slice_a", sl_a, 32'hFFFF0000);
    chk("xor_slice_op", sl_op, 4'b0100);
    chk("xor_out_valid_early", out_valid, 0);
    tick();
    chk("xor_en_once", en, 0);
    chk("xor_out_valid", out_valid, 1);
    chk("xor_out_result", out_result, 32'hF0F00F0F);
    chk("xor_out_opcode", out_opcode, 4'b0100);
    tick();
    chk("xor_drained", out_valid, 0);

    // Unsupported opcode passes the slice's zero through
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    tick();
    chk("unsup_out_valid", out_valid, 1);
    chk("unsup_out_result", out_result, 32'h0);
    chk("unsup_out_opcode", out_opcode, 4'b0001);
    tick();

    // Fill under backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(i), 32'h0, 4'b0100);
      tick();
    end
    drive(1'b1, 32'd6, 32'h0, 4'b0100);
    chk("fill_count_full", count, 4);
    chk("fill_in_ready_low", in_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_held_result", out_result, 1);
    tick();
    chk("fill_sixth_rejected", count, 4);
    chk("fill_held_stable", out_result, 1);
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    out_ready = 1'b1;
    tick();
    chk("fill_in_ready_back", in_ready, 1);
    chk("fill_next_result", out_result, 2);
    repeat (4) tick();
    chk("fill_out_idle", out_valid, 0);
    chk("fill_count_empty", count, 0);
    chk("fill_sb_empty", exp_q.size(), 0);

    // Streaming at one op per cycle
    pops0 = n_pops;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, $urandom, $urandom, 4'b0100);
      tick();
      chk("stream_count_le1", {63'd0, count <= 3'd1}, 1);
      chk("stream_out_valid", {63'd0, out_valid}, {63'd0, i > 0});
    end
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    tick();
    chk("stream_last_valid", out_valid, 1);
    tick();
    chk("stream_idle", out_valid, 0);
    chk("stream_pop_count", n_pops - pops0, 16);

    // Simultaneous push and issue at count=2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 32'h5, 4'b0100);
      tick();
    end
    chk("sim_count_2", count, 2);
    chk("sim_out_valid", out_valid, 1);
    out_ready = 1'b1;
    drive(1'b1, 32'hA3, 32'h5, 4'b0100);
    tick();
    chk("sim_count_stays_2", count, 2);
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    repeat (3) tick();
    chk("sim_count_empty", count, 0);
    chk("sim_sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h11 * 32'(i), 32'h0, 4'b0100);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_result", out_result, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    drive(1'b1, 32'hDEAD, 32'hBEEF, 4'b0100);
    @(posedge clk);
    #1;
    chk("rst_ignores_in_valid", count, 0);
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h12345678, 32'h0000FFFF, 4'b0100);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
    tick();
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_out_result", out_result, 32'h1234A987);
    tick();
    chk("post_rst_idle", out_valid, 0);
    chk("post_rst_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
